// File: rtl/imm_gen_pkg.sv
// Shared opcode constants, format codes and the decoded-result record
// used by the pipelined RV immediate generator.
package imm_gen_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    // imm is carried at the widest legal XLEN; narrower builds use the low bits
    typedef struct packed {
        logic [63:0] imm;
        fmt_e        fmt;
        logic        illegal;
        logic [31:0] instr;
    } result_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode decode and immediate assembly for all RV base
// formats; immediates are sign-extended from instr[31] to XLEN.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0] instr,
    output result_t     res
);

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_x;

    always_comb begin
        res         = '0;
        res.fmt     = FMT_R;
        res.instr   = instr;
        imm32       = '0;
        case (instr[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
                res.fmt = FMT_I;
                imm32   = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_STORE: begin
                res.fmt = FMT_S;
                imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                res.fmt = FMT_B;
                imm32   = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                res.fmt = FMT_U;
                imm32   = {instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                res.fmt = FMT_J;
                imm32   = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_OP:  res.fmt     = FMT_R;
            default: res.illegal = 1'b1;
        endcase
        imm_x   = XLEN'($signed(imm32));
        res.imm = 64'($signed(imm_x));
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: output register plus one-entry skid behind
// a valid/ready handshake. Optional illegal counter: define IMM_ILL_CNT_EN.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int ILL_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_imm,
    output logic [2:0]           out_fmt,
    output logic                 out_illegal,
    output logic [31:0]          out_instr
`ifdef IMM_ILL_CNT_EN
    ,
    output logic [ILL_CNT_W-1:0] ill_cnt
`endif
);

    result_t dec;
    result_t out_res;
    result_t skid_res;
    logic    skid_valid;
    logic    in_fire;
    logic    out_fire;
    logic    out_free;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr (in_instr),
        .res   (dec)
    );

    // in_ready comes straight from the skid flop, so it never sees out_ready
    assign in_ready = !skid_valid;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign out_free = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_res    <= '0;
            skid_valid <= 1'b0;
            skid_res   <= '0;
        end else if (skid_valid) begin
            if (out_free) begin
                out_res    <= skid_res;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end
        end else if (in_fire) begin
            if (out_free) begin
                out_res   <= dec;
                out_valid <= 1'b1;
            end else begin
                skid_res   <= dec;
                skid_valid <= 1'b1;
            end
        end else if (out_free) begin
            out_valid <= 1'b0;
        end
    end

    assign out_imm     = out_res.imm[XLEN-1:0];
    assign out_fmt     = out_res.fmt;
    assign out_illegal = out_res.illegal;
    assign out_instr   = out_res.instr;

`ifdef IMM_ILL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_cnt <= '0;
        end else if (out_fire && out_res.illegal && (ill_cnt != '1)) begin
            ill_cnt <= ill_cnt + ILL_CNT_W'(1);
        end
    end
`else
    logic [ILL_CNT_W-1:0] unused_cnt_w;
    logic                 unused_fire;
    assign unused_cnt_w = '0;
    assign unused_fire  = out_fire;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed vectors, backpressure, reset and a
// scoreboard model checked every cycle. Counter tests need IMM_ILL_CNT_EN.
module tb_imm_gen_pipe;

    localparam int XLEN = 64;
`ifdef IMM_ILL_CNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;
    logic [31:0]     out_instr;
`ifdef IMM_ILL_CNT_EN
    logic [CW-1:0]   ill_cnt;
    logic [CW-1:0]   cnt_model;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] q[$];
    logic [63:0] mask;

    imm_gen_pipe #(.XLEN(XLEN), .ILL_CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_fmt     (out_fmt),
        .out_illegal (out_illegal),
        .out_instr   (out_instr)
`ifdef IMM_ILL_CNT_EN
        ,
        .ill_cnt     (ill_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: immediate derived with arithmetic shifts on the signed word
    function automatic logic [63:0] model(input logic [31:0] w, output logic [2:0] fmt,
                                          output logic ill);
        longint s;
        longint r;
        s   = longint'($signed(w));
        r   = 0;
        fmt = 3'd0;
        ill = 1'b0;
        case (w[6:0])
            7'h03, 7'h13, 7'h67: begin fmt = 3'd1; r = s >>> 20; end
            7'h23: begin fmt = 3'd2; r = ((s >>> 25) <<< 5) + longint'(w[11:7]); end
            7'h63: begin
                fmt = 3'd3;
                r = ((s >>> 31) <<< 12) + (longint'(w[7]) <<< 11)
                  + (longint'(w[30:25]) <<< 5) + (longint'(w[11:8]) <<< 1);
            end
            7'h37, 7'h17: begin fmt = 3'd4; r = s & -64'sd4096; end
            7'h6f: begin
                fmt = 3'd5;
                r = ((s >>> 31) <<< 20) + (longint'(w[19:12]) <<< 12)
                  + (longint'(w[20]) <<< 11) + (longint'(w[30:21]) <<< 1);
            end
            7'h33: fmt = 3'd0;
            default: ill = 1'b1;
        endcase
        return 64'(r) & mask;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
`ifdef IMM_ILL_CNT_EN
            cnt_model <= '0;
`endif
        end else begin
            if (out_valid && out_ready && q.size() > 0) begin
`ifdef IMM_ILL_CNT_EN
                logic [2:0] f;
                logic       il;
                void'(model(q[0], f, il));
                if (il && cnt_model != '1) cnt_model <= cnt_model + 1'b1;
`endif
                void'(q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(in_instr);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("sb_out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("sb_in_ready", 64'(in_ready), 64'(q.size() < 2));
            if (out_valid && q.size() > 0) begin
                logic [2:0]  f;
                logic        il;
                logic [63:0] e;
                e = model(q[0], f, il);
                chk("sb_imm", 64'(out_imm), e);
                chk("sb_fmt", 64'(out_fmt), 64'(f));
                chk("sb_illegal", 64'(out_illegal), 64'(il));
                chk("sb_instr", 64'(out_instr), 64'(q[0]));
            end
`ifdef IMM_ILL_CNT_EN
            chk("sb_ill_cnt", 64'(ill_cnt), 64'(cnt_model));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds in_valid until the word is taken; leaves in_valid high on return
    task automatic send(input logic [31:0] w);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_instr = w;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (n == 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=in_ready_low required=accept");
        end
        step();
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    vec_t vecs[8];

    initial begin
        mask = (XLEN == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        vecs[0] = '{32'hFFC12083, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1'b0};
        vecs[1] = '{32'h00512423, 64'h0000_0000_0000_0008, 3'd2, 1'b0};
        vecs[2] = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0};
        vecs[3] = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0};
        vecs[4] = '{32'h0000007F, 64'h0000_0000_0000_0000, 3'd0, 1'b1};
        vecs[5] = '{32'hFF9FF06F, 64'hFFFF_FFFF_FFFF_FFF8, 3'd5, 1'b0};
        vecs[6] = '{32'h00B50533, 64'h0000_0000_0000_0000, 3'd0, 1'b0};
        vecs[7] = '{32'h00001297, 64'h0000_0000_0000_1000, 3'd4, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_imm", 64'(out_imm), 64'd0);
        chk("rst_out_fmt", 64'(out_fmt), 64'd0);
        chk("rst_out_illegal", 64'(out_illegal), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Directed vectors: latency 1, literal expectations pin DUT and model
        foreach (vecs[i]) begin
            logic [2:0] f;
            logic       il;
            chk("model_imm", model(vecs[i].instr, f, il), vecs[i].imm & mask);
            chk("model_fmt", 64'(f), 64'(vecs[i].fmt));
            send(vecs[i].instr);
            in_valid = 1'b0;
            chk("dir_valid", 64'(out_valid), 64'd1);
            chk("dir_imm", 64'(out_imm), vecs[i].imm & mask);
            chk("dir_fmt", 64'(out_fmt), 64'(vecs[i].fmt));
            chk("dir_illegal", 64'(out_illegal), 64'(vecs[i].ill));
            step();
        end

        // Full throughput with out_ready held high
        foreach (vecs[i]) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            chk("tput_in_ready", 64'(in_ready), 64'd1);
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();

        // Backpressure: two accepted, third waits for the skid to drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00512423;
        step();
        in_instr = 32'h800000B7;
        chk("bp_ready_2nd", 64'(in_ready), 64'd1);
        step();
        chk("bp_ready_low", 64'(in_ready), 64'd0);
        in_instr = 32'h0000007F;
        step();
        chk("bp_ready_held", 64'(in_ready), 64'd0);
        chk("bp_stable_imm", 64'(out_imm), 64'h8);
        out_ready = 1'b1;
        step();
        chk("bp_skid_moved", 64'(out_imm), 64'hFFFF_FFFF_8000_0000 & mask);
        chk("bp_ready_up", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("bp_third_out", 64'(out_illegal), 64'd1);
        repeat (2) step();

        // Random backpressure stream
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send(vecs[$urandom_range(0, 7)].instr);
                    in_valid = 1'b0;
                    if ($urandom_range(0, 2) == 0) step();
                end
            end
            begin
                for (int k = 0; k < 160; k++) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    step();
                end
                out_ready = 1'b1;
            end
        join
        repeat (3) step();

        // Reset with output and skid both occupied
        out_ready = 1'b0;
        send(32'hFFC12083);
        send(32'hFE000EE3);
        in_valid = 1'b0;
        chk("mid_skid_full", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_imm", 64'(out_imm), 64'd0);
        repeat (2) step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            step();
            chk("post_rst_idle", 64'(out_valid), 64'd0);
        end

`ifdef IMM_ILL_CNT_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) send(32'h0000007F);
        in_valid = 1'b0;
        step();
        chk("ill_cnt_3", 64'(ill_cnt), 64'd3);
        for (int i = 0; i < 20; i++) send(32'h0000007F);
        in_valid = 1'b0;
        step();
        chk("ill_cnt_sat", 64'(ill_cnt), 64'(CW'('1)));
`endif

        begin
            int n;
            n = 0;
            while (q.size() > 0 && n < 100) begin
                step();
                n++;
            end
            chk("drain_empty", 64'(q.size()), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
